// File: rtl/imm_encoder_if.sv
// Control codes for immediate formats and the request/response bundle of imm_encoder.
package imm_encoder_pkg;
    localparam int unsigned INST_W = 32;
    localparam int unsigned SEL_W  = 3;

    localparam logic [SEL_W-1:0] IMM_ITYPE = 3'd0;
    localparam logic [SEL_W-1:0] IMM_STYPE = 3'd1;
    localparam logic [SEL_W-1:0] IMM_BTYPE = 3'd2;
    localparam logic [SEL_W-1:0] IMM_UTYPE = 3'd3;
    localparam logic [SEL_W-1:0] IMM_JTYPE = 3'd4;
    localparam logic [SEL_W-1:0] IMM_CSR   = 3'd5;

    localparam logic [6:0] OPC_LUI  = 7'h37;
    localparam logic [6:0] OPC_ADDI = 7'h13;
endpackage

interface imm_encoder_if;
    logic                                in_valid;
    logic                                in_ready;
    logic [imm_encoder_pkg::SEL_W-1:0]   in_sel;
    logic [imm_encoder_pkg::INST_W-1:0]  in_imm;
    logic [imm_encoder_pkg::INST_W-1:0]  in_base;
    logic                                in_li;
    logic                                out_valid;
    logic                                out_ready;
    logic [imm_encoder_pkg::INST_W-1:0]  out_inst;
    logic                                out_err;

    modport master (
        output in_valid, in_sel, in_imm, in_base, in_li, out_ready,
        input  in_ready, out_valid, out_inst, out_err
    );

    modport slave (
        input  in_valid, in_sel, in_imm, in_base, in_li, out_ready,
        output in_ready, out_valid, out_inst, out_err
    );
endinterface

// File: rtl/imm_encoder.sv
// Packs an immediate into an instruction template, or expands a load-immediate
// into ADDI / LUI / LUI+ADDI, with a one-deep registered output stage.
module imm_encoder
    import imm_encoder_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    imm_encoder_if.slave bus
);

    typedef enum logic [1:0] {IDLE, OUT_LAST, OUT_FIRST} state_t;

    state_t              state;
    logic                out_valid_q;
    logic [INST_W-1:0]   out_inst_q;
    logic                out_err_q;
    logic [INST_W-1:0]   pend_inst;

    logic                accept;
    logic [INST_W-1:0]   imm;
    logic [INST_W-1:0]   enc_inst;
    logic                enc_err;
    logic                i_ok;
    logic                b_ok;
    logic                j_ok;

    logic [4:0]          rd;
    logic [19:0]         li_hi;
    logic [11:0]         li_lo;
    logic [INST_W-1:0]   li_first;
    logic [INST_W-1:0]   li_addi;
    logic                li_two;

    logic [INST_W-1:0]   next_inst;
    logic                next_err;

    assign imm = bus.in_imm;

    // Sign-extension checks: the dropped upper bits must all equal the kept sign bit.
    assign i_ok = (&imm[31:11]) | ~(|imm[31:11]);
    assign b_ok = (&imm[31:12]) | ~(|imm[31:12]);
    assign j_ok = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        enc_inst = bus.in_base;
        enc_err  = 1'b0;
        case (bus.in_sel)
            IMM_ITYPE: begin
                enc_inst[31:20] = imm[11:0];
                enc_err         = ~i_ok;
            end
            IMM_STYPE: begin
                enc_inst[31:25] = imm[11:5];
                enc_inst[11:7]  = imm[4:0];
                enc_err         = ~i_ok;
            end
            IMM_BTYPE: begin
                enc_inst[31]    = imm[12];
                enc_inst[30:25] = imm[10:5];
                enc_inst[11:8]  = imm[4:1];
                enc_inst[7]     = imm[11];
                enc_err         = imm[0] | ~b_ok;
            end
            IMM_UTYPE: begin
                enc_inst[31:12] = imm[31:12];
                enc_err         = |imm[11:0];
            end
            IMM_JTYPE: begin
                enc_inst[31]    = imm[20];
                enc_inst[30:21] = imm[10:1];
                enc_inst[20]    = imm[11];
                enc_inst[19:12] = imm[19:12];
                enc_err         = imm[0] | ~j_ok;
            end
            IMM_CSR: begin
                enc_inst[19:15] = imm[4:0];
                enc_err         = |imm[31:5];
            end
            default: begin
                enc_inst = bus.in_base;
                enc_err  = 1'b1;
            end
        endcase
    end

    // Load-immediate: the +0x800 rounding compensates for ADDI sign-extending lo.
    assign rd      = bus.in_base[11:7];
    assign li_hi   = 20'((imm + 32'h0000_0800) >> 12);
    assign li_lo   = imm[11:0];
    assign li_addi = {li_lo, rd, 3'b000, rd, OPC_ADDI};

    always_comb begin
        li_two   = 1'b0;
        li_first = {li_hi, rd, OPC_LUI};
        if (li_hi == 20'd0) begin
            li_first = {li_lo, 5'd0, 3'b000, rd, OPC_ADDI};
        end else if (li_lo != 12'd0) begin
            li_two = 1'b1;
        end
    end

    assign next_inst = bus.in_li ? li_first : enc_inst;
    assign next_err  = bus.in_li ? 1'b0 : enc_err;

    assign bus.in_ready = ~rst & ((state == IDLE) | ((state == OUT_LAST) & bus.out_ready));
    assign accept       = bus.in_valid & bus.in_ready;

    // Output stage and sequencer; accept has priority since it also implies the take.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_err_q   <= 1'b0;
            pend_inst   <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_inst_q  <= next_inst;
            out_err_q   <= next_err;
            if (bus.in_li && li_two) begin
                pend_inst <= li_addi;
                state     <= OUT_FIRST;
            end else begin
                pend_inst <= '0;
                state     <= OUT_LAST;
            end
        end else if (state == OUT_FIRST && bus.out_ready) begin
            out_inst_q <= pend_inst;
            out_err_q  <= 1'b0;
            pend_inst  <= '0;
            state      <= OUT_LAST;
        end else if (state == OUT_LAST && bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_inst  = out_inst_q;
    assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed self-checking bench for imm_encoder: formats, load-immediate, stall, reset.
module tb_imm_encoder;
    import imm_encoder_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    imm_encoder_if bus ();

    imm_encoder u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] imm;
        logic [31:0] base;
        logic [31:0] inst;
        logic        err;
    } fmt_vec_t;

    typedef struct {
        logic [31:0] imm;
        logic [31:0] base;
        logic [31:0] inst;
    } li_vec_t;

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sel    = '0;
        bus.in_imm    = '0;
        bus.in_base   = '0;
        bus.in_li     = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
        end
        checks++;
        if (bus.out_inst !== 32'h0) begin
            failures++; $display("FAIL reset_out_inst got=%h exp=00000000", bus.out_inst);
        end
        checks++;
        if (bus.out_err !== 1'b0) begin
            failures++; $display("FAIL reset_out_err got=%b exp=0", bus.out_err);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL idle_in_ready got=%b exp=1", bus.in_ready);
        end
    endtask

    // Streams every format vector back to back with out_ready held high.
    task automatic test_formats();
        fmt_vec_t v [14];
        v[0]  = '{IMM_ITYPE, 32'hFFFF_FFFB, 32'h0000_0093, 32'hFFB0_0093, 1'b0};
        v[1]  = '{IMM_ITYPE, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1};
        v[2]  = '{IMM_ITYPE, 32'h0000_07FF, 32'h0000_0013, 32'h7FF0_0013, 1'b0};
        v[3]  = '{IMM_STYPE, 32'hFFFF_F800, 32'h0000_0023, 32'h8000_0023, 1'b0};
        v[4]  = '{IMM_STYPE, 32'h0000_0FFF, 32'h0000_0023, 32'hFE00_0FA3, 1'b1};
        v[5]  = '{IMM_BTYPE, 32'hFFFF_FFFE, 32'h0000_0063, 32'hFE00_0FE3, 1'b0};
        v[6]  = '{IMM_BTYPE, 32'h0000_1000, 32'h0000_0063, 32'h8000_0063, 1'b1};
        v[7]  = '{IMM_BTYPE, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 1'b1};
        v[8]  = '{IMM_UTYPE, 32'hABCD_E000, 32'h0000_0037, 32'hABCD_E037, 1'b0};
        v[9]  = '{IMM_UTYPE, 32'h0000_1001, 32'h0000_0037, 32'h0000_1037, 1'b1};
        v[10] = '{IMM_JTYPE, 32'h000F_FFFE, 32'h0000_006F, 32'h7FFF_F06F, 1'b0};
        v[11] = '{IMM_JTYPE, 32'h0010_0000, 32'h0000_006F, 32'h8000_006F, 1'b1};
        v[12] = '{IMM_CSR,   32'h0000_001F, 32'h0000_2073, 32'h000F_A073, 1'b0};
        v[13] = '{IMM_CSR,   32'h0000_0020, 32'h0000_2073, 32'h0000_2073, 1'b1};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            bus.in_sel   = v[i].sel;
            bus.in_imm   = v[i].imm;
            bus.in_base  = v[i].base;
            bus.in_li    = 1'b0;
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b1) begin
                failures++; $display("FAIL fmt%0d_valid got=%b exp=1", i, bus.out_valid);
            end
            checks++;
            if (bus.out_inst !== v[i].inst) begin
                failures++; $display("FAIL fmt%0d_inst got=%h exp=%h", i, bus.out_inst, v[i].inst);
            end
            checks++;
            if (bus.out_err !== v[i].err) begin
                failures++; $display("FAIL fmt%0d_err got=%b exp=%b", i, bus.out_err, v[i].err);
            end
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL fmt_drain_valid got=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_undefined_sel();
        @(negedge clk);
        bus.in_sel   = 3'd7;
        bus.in_imm   = 32'hFFFF_FFFF;
        bus.in_base  = 32'h1234_5678;
        bus.in_li    = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_inst !== 32'h1234_5678) begin
            failures++; $display("FAIL undef_inst got=%h exp=12345678", bus.out_inst);
        end
        checks++;
        if (bus.out_err !== 1'b1) begin
            failures++; $display("FAIL undef_err got=%b exp=1", bus.out_err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_li_pair();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_li    = 1'b1;
        bus.in_sel   = 3'd7;
        bus.in_base  = 32'h0000_0280;
        bus.in_imm   = 32'h1234_5FFF;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_li    = 1'b0;
        bus.in_imm   = 32'hDEAD_BEEF;
        bus.in_base  = 32'hFFFF_FFFF;
        checks++;
        if (bus.out_inst !== 32'h1234_62B7) begin
            failures++; $display("FAIL li_lui_inst got=%h exp=123462b7", bus.out_inst);
        end
        checks++;
        if (bus.out_err !== 1'b0) begin
            failures++; $display("FAIL li_lui_err got=%b exp=0", bus.out_err);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++; $display("FAIL li_first_in_ready got=%b exp=0", bus.in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_inst !== 32'hFFF2_8293) begin
            failures++; $display("FAIL li_addi_inst got=%h exp=fff28293", bus.out_inst);
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            failures++; $display("FAIL li_addi_valid got=%b exp=1", bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL li_last_in_ready got=%b exp=1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL li_pair_done_valid got=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_li_single();
        li_vec_t v [3];
        v[0] = '{32'h0000_0005, 32'h0000_0080, 32'h0050_0093};
        v[1] = '{32'h0001_0000, 32'h0000_0080, 32'h0001_00B7};
        v[2] = '{32'hFFFF_F800, 32'h0000_0080, 32'h8000_0093};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_li    = 1'b1;
            bus.in_sel   = 3'd6;
            bus.in_imm   = v[i].imm;
            bus.in_base  = v[i].base;
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            bus.in_li    = 1'b0;
            checks++;
            if (bus.out_inst !== v[i].inst) begin
                failures++; $display("FAIL li_single%0d_inst got=%h exp=%h", i, bus.out_inst, v[i].inst);
            end
            checks++;
            if (bus.out_err !== 1'b0) begin
                failures++; $display("FAIL li_single%0d_err got=%b exp=0", i, bus.out_err);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                failures++; $display("FAIL li_single%0d_extra_valid got=%b exp=0", i, bus.out_valid);
            end
        end
    endtask

    task automatic test_stall_back_to_back();
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_li    = 1'b0;
        bus.in_sel   = IMM_UTYPE;
        bus.in_imm   = 32'hABCD_E000;
        bus.in_base  = 32'h0000_0037;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.in_sel   = IMM_ITYPE;
        bus.in_imm   = 32'h0000_07FF;
        bus.in_base  = 32'h0000_0013;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b1) begin
                failures++; $display("FAIL stall%0d_valid got=%b exp=1", c, bus.out_valid);
            end
            checks++;
            if (bus.out_inst !== 32'hABCD_E037) begin
                failures++; $display("FAIL stall%0d_inst got=%h exp=abcde037", c, bus.out_inst);
            end
            checks++;
            if (bus.in_ready !== 1'b0) begin
                failures++; $display("FAIL stall%0d_in_ready got=%b exp=0", c, bus.in_ready);
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL drain_in_ready got=%b exp=1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1) begin
            failures++; $display("FAIL b2b_valid got=%b exp=1", bus.out_valid);
        end
        checks++;
        if (bus.out_inst !== 32'h7FF0_0013) begin
            failures++; $display("FAIL b2b_inst got=%h exp=7ff00013", bus.out_inst);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_done_valid got=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid_li();
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_li    = 1'b1;
        bus.in_base  = 32'h0000_0280;
        bus.in_imm   = 32'h1234_5FFF;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_li    = 1'b0;
        checks++;
        if (bus.out_inst !== 32'h1234_62B7) begin
            failures++; $display("FAIL rstmid_lui_inst got=%h exp=123462b7", bus.out_inst);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL rstmid_out_valid got=%b exp=0", bus.out_valid);
        end
        checks++;
        if (bus.out_inst !== 32'h0) begin
            failures++; $display("FAIL rstmid_out_inst got=%h exp=00000000", bus.out_inst);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++; $display("FAIL rstmid_in_ready got=%b exp=0", bus.in_ready);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                failures++; $display("FAIL rstmid_no_addi%0d got=%b exp=0", c, bus.out_valid);
            end
        end
        @(negedge clk);
        bus.in_sel   = IMM_ITYPE;
        bus.in_imm   = 32'hFFFF_FFFB;
        bus.in_base  = 32'h0000_0093;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_inst !== 32'hFFB0_0093) begin
            failures++; $display("FAIL post_rst_inst got=%h exp=ffb00093", bus.out_inst);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL post_rst_done_valid got=%b exp=0", bus.out_valid);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_formats();
        test_undefined_sel();
        test_li_pair();
        test_li_single();
        test_stall_back_to_back();
        test_reset_mid_li();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
